// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues one imem request
// at a time and loads the IF/ID register under stall/redirect control.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   npc, redirect     redirect target and strobe resolved in EX
//   stall             hazard-unit hold of IF/ID and PC advance
//   imem_rvalid/rdata instruction memory response
//   imem_req/addr     registered request pulse and its address
//   pc, pc_plus4      current fetch PC and PC+4 to the next-PC unit
//   ifid_*            IF/ID pipeline register contents
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    input  logic        redirect,
    input  logic        stall,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic [31:0] ifid_instr
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP,
        HOLD
    } state_t;

    // What happens to IF/ID on the coming edge.
    typedef enum logic [1:0] {
        OP_HOLD,
        OP_BUBBLE,
        OP_LIVE,
        OP_BUF
    } ifid_op_t;

    state_t      state;
    state_t      state_nx;
    ifid_op_t    op;

    logic [31:0] pc_q;
    logic [31:0] pc_nx;
    logic        req_q;
    logic        req_nx;
    logic [31:0] buf_q;
    logic [31:0] buf_nx;
    logic [31:0] target;

    logic        v_q;
    logic        v_nx;
    logic [31:0] ipc_q;
    logic [31:0] ipc_nx;
    logic [31:0] ip4_q;
    logic [31:0] ip4_nx;
    logic [31:0] ins_q;
    logic [31:0] ins_nx;

    assign pc            = pc_q;
    assign pc_plus4      = pc_q + 32'd4;
    assign imem_req      = req_q;
    assign imem_addr     = pc_q;
    assign ifid_valid    = v_q;
    assign ifid_pc       = ipc_q;
    assign ifid_pc_plus4 = ip4_q;
    assign ifid_instr    = ins_q;

    // Redirect targets are always word aligned.
    assign target = npc & 32'hFFFF_FFFC;

    always_comb begin
        state_nx = state;
        pc_nx    = pc_q;
        req_nx   = 1'b0;
        buf_nx   = buf_q;
        op       = OP_HOLD;
        unique case (state)
            IDLE: begin
                // Any response seen here belongs to a pre-reset request.
                req_nx   = 1'b1;
                state_nx = WAIT;
                if (redirect) begin
                    pc_nx = target;
                    op    = OP_BUBBLE;
                end else if (!stall) begin
                    op = OP_BUBBLE;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (redirect) begin
                        pc_nx  = target;
                        op     = OP_BUBBLE;
                        req_nx = 1'b1;
                    end else if (stall) begin
                        buf_nx   = imem_rdata;
                        state_nx = HOLD;
                    end else begin
                        op     = OP_LIVE;
                        pc_nx  = pc_plus4;
                        req_nx = 1'b1;
                    end
                end else if (redirect) begin
                    // Request still in flight: its answer is stale.
                    pc_nx    = target;
                    op       = OP_BUBBLE;
                    state_nx = DROP;
                end else if (!stall) begin
                    op = OP_BUBBLE;
                end
            end
            DROP: begin
                if (redirect) begin
                    pc_nx = target;
                end
                if (redirect || !stall) begin
                    op = OP_BUBBLE;
                end
                if (imem_rvalid) begin
                    req_nx   = 1'b1;
                    state_nx = WAIT;
                end
            end
            HOLD: begin
                if (redirect) begin
                    buf_nx   = '0;
                    pc_nx    = target;
                    op       = OP_BUBBLE;
                    req_nx   = 1'b1;
                    state_nx = WAIT;
                end else if (!stall) begin
                    buf_nx   = '0;
                    op       = OP_BUF;
                    pc_nx    = pc_plus4;
                    req_nx   = 1'b1;
                    state_nx = WAIT;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        v_nx   = v_q;
        ipc_nx = ipc_q;
        ip4_nx = ip4_q;
        ins_nx = ins_q;
        unique case (op)
            OP_BUBBLE: begin
                v_nx   = 1'b0;
                ins_nx = NOP;
            end
            OP_LIVE: begin
                v_nx   = 1'b1;
                ipc_nx = pc_q;
                ip4_nx = pc_plus4;
                ins_nx = imem_rdata;
            end
            OP_BUF: begin
                v_nx   = 1'b1;
                ipc_nx = pc_q;
                ip4_nx = pc_plus4;
                ins_nx = buf_q;
            end
            default: begin
                v_nx = v_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc_q  <= RESET_PC;
            req_q <= 1'b0;
            buf_q <= '0;
            v_q   <= 1'b0;
            ipc_q <= '0;
            ip4_q <= '0;
            ins_q <= NOP;
        end else begin
            state <= state_nx;
            pc_q  <= pc_nx;
            req_q <= req_nx;
            buf_q <= buf_nx;
            v_q   <= v_nx;
            ipc_q <= ipc_nx;
            ip4_q <= ip4_nx;
            ins_q <= ins_nx;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: scoreboard of expected IF/ID entries
// pushed when a response is driven, popped when IF/ID becomes valid.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] npc = '0;
    logic        redirect = 1'b0;
    logic        stall = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic [31:0] ifid_instr;

    int checks = 0;
    int errors = 0;
    logic [95:0] sb[$];

    if_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk          (clk),
        .rst          (rst),
        .npc          (npc),
        .redirect     (redirect),
        .stall        (stall),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .ifid_valid   (ifid_valid),
        .ifid_pc      (ifid_pc),
        .ifid_pc_plus4(ifid_pc_plus4),
        .ifid_instr   (ifid_instr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] w);
        sb.push_back({a, a + 32'd4, w});
    endtask

    task automatic pop_check(input string tag);
        logic [95:0] e;
        chk({tag, "_valid"}, {31'd0, ifid_valid}, 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_pc"}, ifid_pc, e[95:64]);
            chk({tag, "_pc4"}, ifid_pc_plus4, e[63:32]);
            chk({tag, "_instr"}, ifid_instr, e[31:0]);
        end
    endtask

    task automatic wait_req(input string tag, input logic [31:0] a);
        for (int i = 0; i < 20; i++) begin
            if (imem_req === 1'b1) break;
            tick();
        end
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        chk({tag, "_addr"}, imem_addr, a);
    endtask

    task automatic bubble(input string tag);
        chk({tag, "_bub_v"}, {31'd0, ifid_valid}, 32'd0);
        chk({tag, "_bub_i"}, ifid_instr, NOP);
    endtask

    // One-cycle memory: current cycle is the request cycle.
    task automatic fetch1(input string tag, input logic [31:0] a,
                          input logic [31:0] w);
        wait_req(tag, a);
        push(a, w);
        tick();
        bubble(tag);
        imem_rvalid = 1'b1;
        imem_rdata  = w;
        tick();
        imem_rvalid = 1'b0;
        pop_check(tag);
    endtask

    initial begin
        // Reset
        tick();
        tick();
        chk("rst_pc", pc, 32'h100);
        chk("rst_pc4", pc_plus4, 32'h104);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h100);
        chk("rst_v", {31'd0, ifid_valid}, 32'd0);
        chk("rst_ipc", ifid_pc, 32'd0);
        chk("rst_ip4", ifid_pc_plus4, 32'd0);
        chk("rst_ins", ifid_instr, NOP);
        rst = 1'b0;

        // Sequential fetch, one-cycle memory
        fetch1("seqA", 32'h100, 32'hA);
        fetch1("seqB", 32'h104, 32'hB);
        fetch1("seqC", 32'h108, 32'hC);

        // Stall over a response
        wait_req("st", 32'h10C);
        stall = 1'b1;
        tick();
        chk("st_hold1", ifid_pc, 32'h108);
        chk("st_hold1i", ifid_instr, 32'hC);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hD;
        push(32'h10C, 32'hD);
        tick();
        imem_rvalid = 1'b0;
        chk("st_hold2", ifid_pc, 32'h108);
        chk("st_hold2v", {31'd0, ifid_valid}, 32'd1);
        chk("st_noreq2", {31'd0, imem_req}, 32'd0);
        tick();
        chk("st_hold3", ifid_instr, 32'hC);
        chk("st_noreq3", {31'd0, imem_req}, 32'd0);
        stall = 1'b0;
        tick();
        pop_check("st_rel");
        chk("st_req", {31'd0, imem_req}, 32'd1);
        chk("st_addr", imem_addr, 32'h110);

        // Redirect while a 3-cycle request is outstanding
        tick();
        redirect = 1'b1;
        npc      = 32'h200;
        tick();
        redirect = 1'b0;
        chk("rd_pc", pc, 32'h200);
        bubble("rd");
        chk("rd_noreq", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD;
        tick();
        imem_rvalid = 1'b0;
        bubble("rd_late");
        fetch1("rdE", 32'h200, 32'hE);

        // Redirect plus stall while holding a buffered word
        wait_req("hr", 32'h204);
        tick();
        stall       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hF;
        tick();
        imem_rvalid = 1'b0;
        redirect    = 1'b1;
        npc         = 32'h303;
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        chk("hr_pc", pc, 32'h300);
        bubble("hr");
        fetch1("hr11", 32'h300, 32'h11);

        // Reset while a request is outstanding
        wait_req("rs", 32'h304);
        tick();
        rst = 1'b1;
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h99;
        tick();
        imem_rvalid = 1'b0;
        chk("rs_pc", pc, 32'h100);
        chk("rs_ipc", ifid_pc, 32'd0);
        bubble("rs");
        rst         = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h77;
        tick();
        imem_rvalid = 1'b0;
        bubble("rs_idle");
        fetch1("rs21", 32'h100, 32'h21);

        // Fetch at the top of the address space
        wait_req("wr", 32'h104);
        redirect = 1'b1;
        npc      = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        chk("wr_pc", pc, 32'hFFFF_FFFC);
        chk("wr_pc4", pc_plus4, 32'd0);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h55;
        tick();
        imem_rvalid = 1'b0;
        fetch1("wr31", 32'hFFFF_FFFC, 32'h31);
        chk("wr_next", imem_addr, 32'd0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
